// File: rtl/pc_pkg.sv
// Shared types and sizing helpers for the SAP-1.5 program sequencer.
// The package itself has no configuration macros.
package pc_pkg;

    // Operations that the control unit can request, one per cycle.
    // Encodings 6 and 7 are not defined and act as HOLD.
    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_JMP  = 3'd2,
        PC_REL  = 3'd3,
        PC_CALL = 3'd4,
        PC_RET  = 3'd5
    } pc_op_t;

    localparam int PC_OP_W = 3;

    // Width of an occupancy count that must hold every value from 0 to depth.
    function automatic int depth_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of an index into a stack of the given depth (at least 1 bit).
    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO return-address stack for the program sequencer.
// The top of stack is read combinationally, so a RET needs no extra cycle.
// Only the depth counter is reset; the stored entries are don't-care after reset.
// There are no configuration macros.
module return_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               push_data,
    output logic [WIDTH-1:0]               top_data,
    output logic [depth_width(DEPTH)-1:0]  depth,
    output logic                           full,
    output logic                           empty
);

    localparam int DW = depth_width(DEPTH);
    localparam int AW = index_width(DEPTH);

    // The array is rounded up to a power of two so every index value is in range.
    logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0]    depth_q;
    logic [DW-1:0]    depth_d;
    logic [DW-1:0]    depth_m1;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full     = (depth_q == DW'(DEPTH));
    assign empty    = (depth_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign depth_m1 = depth_q - DW'(1);
    assign wr_idx   = depth_q[AW-1:0];
    assign rd_idx   = depth_m1[AW-1:0];
    assign top_data = mem_q[rd_idx];
    assign depth    = depth_q;

    // Occupancy changes by one on a push or a pop; both at once leave it unchanged.
    always_comb begin
        depth_d = depth_q;
        if (do_push && !do_pop) begin
            depth_d = depth_q + DW'(1);
        end else if (do_pop && !do_push) begin
            depth_d = depth_m1;
        end
    end

    // Depth register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entry storage is written only at the first free slot, so occupied entries are never overwritten.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// SAP-1.5 program counter with increment, absolute jump, relative branch,
// and subroutine call/return through an internal return stack.
// Macro PC_REL_BRANCH_EN: when defined, REL adds a sign-extended offset to
// the PC. When it is undefined, REL acts as HOLD and offset_in is ignored.
module program_sequencer
    import pc_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 4,
    parameter int          STACK_DEPTH  = 4,
    parameter int          OFFSET_WIDTH = 4,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [PC_OP_W-1:0]                   op,
    input  logic [ADDR_WIDTH-1:0]                counter_in,
    input  logic [OFFSET_WIDTH-1:0]              offset_in,
    input  logic                                 clear_flags,
    output logic [ADDR_WIDTH-1:0]                counter_out,
    output logic [depth_width(STACK_DEPTH)-1:0]  stack_depth,
    output logic                                 stack_empty,
    output logic                                 stack_full,
    output logic                                 stack_ovf,
    output logic                                 stack_unf
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic                  unf_q;
    logic                  unf_d;
    logic [ADDR_WIDTH-1:0] pc_plus1;
    logic [ADDR_WIDTH-1:0] top_data;
    logic                  push;
    logic                  pop;
    logic                  st_full;
    logic                  st_empty;
    pc_op_t                op_e;

    assign op_e     = pc_op_t'(op);
    assign pc_plus1 = pc_q + ADDR_WIDTH'(1);

`ifdef PC_REL_BRANCH_EN
    logic signed [ADDR_WIDTH-1:0] off_ext;
    logic        [ADDR_WIDTH-1:0] pc_rel;
    // The branch base is the current PC, not PC+1.
    assign off_ext = ADDR_WIDTH'($signed(offset_in));
    assign pc_rel  = pc_q + off_ext;
`else
    logic unused_offset;
    assign unused_offset = ^offset_in;
`endif

    return_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus1),
        .top_data  (top_data),
        .depth     (stack_depth),
        .full      (st_full),
        .empty     (st_empty)
    );

    // Op decode and next-PC mux. A new error outranks a flag clear in the same cycle.
    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        pop   = 1'b0;
        if (clear_flags) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (enable) begin
            case (op_e)
                PC_INC:  pc_d = pc_plus1;
                PC_JMP:  pc_d = counter_in;
                PC_REL: begin
`ifdef PC_REL_BRANCH_EN
                    pc_d = pc_rel;
`endif
                end
                PC_CALL: begin
                    if (st_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        pc_d = counter_in;
                    end
                end
                PC_RET: begin
                    if (st_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        pc_d = top_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // PC and sticky error flags, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= ADDR_WIDTH'(RESET_VECTOR);
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign counter_out = pc_q;
    assign stack_empty = st_empty;
    assign stack_full  = st_full;
    assign stack_ovf   = ovf_q;
    assign stack_unf   = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed testbench for program_sequencer (RESET_VECTOR=3, other parameters default).
// Expected values for REL depend on whether PC_REL_BRANCH_EN is defined.
module tb_program_sequencer;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] op;
    logic [3:0] counter_in;
    logic [3:0] offset_in;
    logic       clear_flags;
    logic [3:0] counter_out;
    logic [2:0] stack_depth;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_ovf;
    logic       stack_unf;

    int checks_cnt;
    int errors_cnt;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_INC  = 3'd1;
    localparam logic [2:0] OP_JMP  = 3'd2;
    localparam logic [2:0] OP_REL  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;

    program_sequencer #(
        .ADDR_WIDTH   (4),
        .STACK_DEPTH  (4),
        .OFFSET_WIDTH (4),
        .RESET_VECTOR (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .op          (op),
        .counter_in  (counter_in),
        .offset_in   (offset_in),
        .clear_flags (clear_flags),
        .counter_out (counter_out),
        .stack_depth (stack_depth),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Apply one operation for exactly one rising edge, then sample 1 time unit later.
    task automatic step(input logic [2:0] o, input logic [3:0] cin, input logic [3:0] off);
        op         = o;
        counter_in = cin;
        offset_in  = off;
        @(posedge clk);
        #1;
        op = OP_HOLD;
    endtask

    task automatic check_state(input string tag, input int pc, input int dep,
                               input int emp, input int ful, input int ovf, input int unf);
        check_val({tag, ".pc"},    int'(counter_out), pc);
        check_val({tag, ".depth"}, int'(stack_depth), dep);
        check_val({tag, ".empty"}, int'(stack_empty), emp);
        check_val({tag, ".full"},  int'(stack_full),  ful);
        check_val({tag, ".ovf"},   int'(stack_ovf),   ovf);
        check_val({tag, ".unf"},   int'(stack_unf),   unf);
    endtask

    int rel_a;
    int rel_b;

    initial begin
        checks_cnt  = 0;
        errors_cnt  = 0;
        reset       = 1'b1;
        enable      = 1'b0;
        op          = OP_HOLD;
        counter_in  = 4'd0;
        offset_in   = 4'd0;
        clear_flags = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 3, 0, 1, 0, 0, 0);

        // Release between edges; first active edge executes from the reset vector.
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            step(OP_INC, 4'd0, 4'd0);
            check_val($sformatf("inc%0d.pc", i), int'(counter_out), (3 + i) % 16);
        end

        // Relative branches, chained from PC=5.
        step(OP_JMP, 4'd5, 4'd0);
        check_val("jmp5.pc", int'(counter_out), 5);
`ifdef PC_REL_BRANCH_EN
        rel_a = 3;
        rel_b = 10;
`else
        rel_a = 5;
        rel_b = 5;
`endif
        step(OP_REL, 4'd0, 4'b1110);
        check_val("rel_m2.pc", int'(counter_out), rel_a);
        step(OP_REL, 4'd0, 4'd7);
        check_val("rel_p7.pc", int'(counter_out), rel_b);

        // Undefined encodings hold.
        step(3'd6, 4'd9, 4'd1);
        check_val("op6.pc", int'(counter_out), rel_b);
        step(3'd7, 4'd9, 4'd1);
        check_val("op7.pc", int'(counter_out), rel_b);

        // Nested call/return from PC=2.
        step(OP_JMP, 4'd2, 4'd0);
        check_val("jmp2.pc", int'(counter_out), 2);
        step(OP_CALL, 4'd9, 4'd0);
        check_state("call9", 9, 1, 0, 0, 0, 0);
        step(OP_CALL, 4'd12, 4'd0);
        check_state("call12", 12, 2, 0, 0, 0, 0);
        step(OP_RET, 4'd0, 4'd0);
        check_state("ret1", 10, 1, 0, 0, 0, 0);
        step(OP_RET, 4'd0, 4'd0);
        check_state("ret2", 3, 0, 1, 0, 0, 0);

        // Fill the stack: pushes 4, 9, 10, 11.
        step(OP_CALL, 4'd8, 4'd0);
        step(OP_CALL, 4'd9, 4'd0);
        step(OP_CALL, 4'd10, 4'd0);
        step(OP_CALL, 4'd11, 4'd0);
        check_state("fill", 11, 4, 0, 1, 0, 0);
        step(OP_CALL, 4'd7, 4'd0);
        check_state("ovf", 11, 4, 0, 1, 1, 0);

        // Clear works while disabled.
        enable      = 1'b0;
        clear_flags = 1'b1;
        step(OP_HOLD, 4'd0, 4'd0);
        clear_flags = 1'b0;
        enable      = 1'b1;
        check_val("clr.ovf", int'(stack_ovf), 0);

        // A new overflow in the same cycle as a clear leaves the flag set.
        clear_flags = 1'b1;
        step(OP_CALL, 4'd7, 4'd0);
        clear_flags = 1'b0;
        check_state("ovf_vs_clr", 11, 4, 0, 1, 1, 0);
        clear_flags = 1'b1;
        step(OP_HOLD, 4'd0, 4'd0);
        clear_flags = 1'b0;
        check_val("clr2.ovf", int'(stack_ovf), 0);

        // Drain in LIFO order.
        step(OP_RET, 4'd0, 4'd0);
        check_state("pop_a", 11, 3, 0, 0, 0, 0);
        step(OP_RET, 4'd0, 4'd0);
        check_val("pop_b.pc", int'(counter_out), 10);
        step(OP_RET, 4'd0, 4'd0);
        check_val("pop_c.pc", int'(counter_out), 9);
        step(OP_RET, 4'd0, 4'd0);
        check_state("pop_d", 4, 0, 1, 0, 0, 0);

        // Underflow.
        step(OP_RET, 4'd0, 4'd0);
        check_state("unf", 4, 0, 1, 0, 0, 1);

        // Disabled: INC has no effect.
        enable = 1'b0;
        step(OP_INC, 4'd0, 4'd0);
        check_val("dis.pc", int'(counter_out), 4);
        enable = 1'b1;

        // Return address wraps: CALL from 15 pushes 0.
        step(OP_JMP, 4'd15, 4'd0);
        step(OP_CALL, 4'd1, 4'd0);
        check_val("wcall.pc", int'(counter_out), 1);
        step(OP_RET, 4'd0, 4'd0);
        check_val("wret.pc", int'(counter_out), 0);

        // Asynchronous reset in the middle of a CALL burst at depth 3.
        step(OP_CALL, 4'd5, 4'd0);
        step(OP_CALL, 4'd6, 4'd0);
        step(OP_CALL, 4'd7, 4'd0);
        check_state("burst3", 7, 3, 0, 0, 0, 1);
        op         = OP_CALL;
        counter_in = 4'd8;
        #2;
        reset = 1'b1;
        #1;
        check_state("async_rst", 3, 0, 1, 0, 0, 0);
        #1;
        reset = 1'b0;
        step(OP_INC, 4'd0, 4'd0);
        check_state("post_rst", 4, 0, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Next-generation program counter for the SAP-1.5 control path. It adds relative branching, subroutine call/return through an internal return-address stack, and a configurable reset vector on top of increment and absolute load. It sits between the control unit, which issues one operation per cycle, and the memory address register, which consumes `counter_out`.

## Interface
- `ADDR_WIDTH`, default 4: program-counter width in bits.
- `STACK_DEPTH`, default 4: number of return-stack entries (≥1).
- `OFFSET_WIDTH`, default 4: width of the signed relative-branch offset (≤ ADDR_WIDTH).
- `RESET_VECTOR`, default 0: value loaded into the counter on reset.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  qualifies `op`; when low the block holds all state.
- `op`  in  `pc_op_t` (3)  requested operation.
- `counter_in`  in  ADDR_WIDTH  absolute target for JMP/CALL.
- `offset_in`  in  OFFSET_WIDTH  signed two's-complement offset for REL.
- `clear_flags`  in  1  clears the sticky error flags.
- `counter_out`  out  ADDR_WIDTH  current PC.
- `stack_depth`  out  $clog2(STACK_DEPTH+1)  number of occupied entries.
- `stack_empty`  out  1  high when `stack_depth` == 0.
- `stack_full`  out  1  high when `stack_depth` == STACK_DEPTH.
- `stack_ovf`  out  1  sticky: a CALL was issued while the stack was full.
- `stack_unf`  out  1  sticky: a RET was issued while the stack was empty.

## Operation
- Reset, asynchronous: `counter_out`=RESET_VECTOR, `stack_depth`=0, `stack_empty`=1, `stack_full`=0, `stack_ovf`=0, `stack_unf`=0. Stack contents are don't-care.
- When `enable`=0, nothing changes except the flag clear.
- When `enable`=1, `op` selects the action:
  - HOLD: no change.
  - INC: PC ← PC+1, modulo 2^ADDR_WIDTH. All-ones wraps to 0.
  - JMP: PC ← `counter_in`.
  - REL: PC ← PC + sign-extended `offset_in`, modulo 2^ADDR_WIDTH. The base is the current PC, not PC+1.
  - CALL, stack not full: push PC+1 (wrapped) and set PC ← `counter_in`; depth increments.
  - CALL, stack full: PC and stack unchanged; `stack_ovf` ← 1.
  - RET, stack not empty: PC ← top-of-stack, pop; depth decrements.
  - RET, stack empty: PC unchanged; `stack_unf` ← 1.
  - Undefined encodings behave as HOLD.
- If `clear_flags` and a new error occur in the same cycle, the set wins.
- The stack is LIFO with no wrap. Entries are never overwritten while occupied.
- There is no FSM. The design is datapath plus a depth counter.

## Timing
- All state updates on the rising `clk` edge, with single-cycle latency: `op` sampled at edge N is reflected on `counter_out` after edge N.
- All outputs are registered or derived directly from registered depth. There is no combinational path from input to output.
- A RET reads top-of-stack combinationally from the stack array in the same cycle, so no bubble is needed.
- Back-to-back CALL/RET on consecutive cycles is legal at full rate.
- Reset asserted mid-sequence aborts immediately. On reset release, the first active edge executes `op` from RESET_VECTOR.

## Configuration
- `PC_REL_BRANCH_EN` defined: the REL operation is implemented as above.
- `PC_REL_BRANCH_EN` undefined:
  - REL decodes as HOLD.
  - `offset_in` remains on the port list but is ignored.
  - The sign-extend adder is removed.

## Structure
- Package `pc_pkg`:
  - `pc_op_t` enum: PC_HOLD=0, PC_INC=1, PC_JMP=2, PC_REL=3, PC_CALL=4, PC_RET=5.
  - Shared localparams for the depth-width calculation.
- Sub-module `return_stack`, parametrised by width and depth:
  - Inputs: push, pop, `push_data`.
  - Outputs: `top_data`, depth, full, empty.
  - Asynchronous reset of the depth counter only.
- `program_sequencer` owns op decode, the next-PC mux, and the sticky flags.

## Test plan
- Reset with RESET_VECTOR=3, then INC ×13 → PC sequence 3…15, 0 (wrap).
- PC=5:
  - REL offset=4'b1110 (−2) → PC=3.
  - REL offset=4'd7 → PC=10.
  - Without `PC_REL_BRANCH_EN`, PC stays 5.
- PC=2:
  - CALL 9 → PC=9, depth=1.
  - CALL 12 → PC=12, depth=2.
  - RET → PC=10, depth=1.
  - RET → PC=3, depth=0, `stack_empty`=1.
- Four CALLs fill the stack (`stack_full`=1). A fifth CALL to 7 → PC unchanged, `stack_ovf`=1, depth=4. Then `clear_flags` → `stack_ovf`=0.
- RET on empty stack → PC unchanged, `stack_unf`=1. `enable`=0 with op=INC → PC unchanged.
- Assert `reset` asynchronously between edges during a CALL burst with depth=3 → outputs go to reset values immediately, before the next edge.
